seq_pattern_gen: RTL and testbench

//  Serial bit-pattern transmitter: the driving end of the team's serial sequence-detector path.

---
 rtl/seq_gen_pkg.sv | 22 ++
 rtl/seq_gen_shifter.sv | 74 +++++++
 rtl/seq_pattern_gen.sv | 190 +++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
//   Shared definitions for the serial pattern generator slice:
//     * state_t   : FSM encoding used by seq_pattern_gen
//     * DEF_*_W   : default widths for the pattern, repeat count and gap length
// -----------------------------------------------------------------------------
package seq_gen_pkg;

  // Default widths; the top level exposes them as overridable parameters.
  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP_W = 3;

  // The state register describes what the outputs show in the current cycle.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_gen_shifter.sv
// -----------------------------------------------------------------------------
// seq_gen_shifter
//   Pattern store with a down-counting bit index. The index always points at
//   the bit shown on the serial line in the current cycle; each shift moves it
//   one position towards bit 0 and wraps back to len-1 after bit 0, so
//   back-to-back repetitions need no reload.
//
// Ports
//   clk       in   1      clock
//   reset     in   1      synchronous, active-high; clears all state
//   load      in   1      capture data/len and point at bit len-1
//   shift     in   1      advance to the next bit (wraps after bit 0)
//   data      in   PAT_W  pattern to capture
//   len       in   LEN_W  pattern length to capture (1..PAT_W)
//   cur_bit   out  1      stored pattern bit at the current index
//   nxt_bit   out  1      stored pattern bit the next shift will point at
//   load_bit  out  1      bit len-1 of the incoming data (first bit after load)
//   last_bit  out  1      current index is bit 0
// -----------------------------------------------------------------------------
module seq_gen_shifter #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] data,
  input  logic [LEN_W-1:0] len,
  output logic             cur_bit,
  output logic             nxt_bit,
  output logic             load_bit,
  output logic             last_bit
);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] step_idx;

  // Bit select that stays in range for any index value; out-of-range
  // indices read as 0.
  function automatic logic pick_bit(input logic [PAT_W-1:0] d,
                                    input logic [LEN_W-1:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < PAT_W; i++) begin
      if (idx == LEN_W'(i)) b = d[i];
    end
    return b;
  endfunction

  assign last_bit = (cnt_q == '0);
  assign step_idx = last_bit ? (len_q - LEN_W'(1)) : (cnt_q - LEN_W'(1));

  assign cur_bit  = pick_bit(pat_q, cnt_q);
  assign nxt_bit  = pick_bit(pat_q, step_idx);
  assign load_bit = pick_bit(data, len - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      pat_q <= data;
      len_q <= len;
      cnt_q <= len - LEN_W'(1);
    end else if (shift) begin
      cnt_q <= step_idx;
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
//   Serial bit-pattern transmitter. On an accepted start it sends the low
//   pat_len bits of pat_data MSB-first, one bit per clock, repeated
//   repeat_cnt times (0 = until stop) with gap_len idle bit-times between
//   repetitions. stop ends the run at the next pattern boundary; a pattern is
//   never cut short except by reset.
//
// Ports
//   clk         in   1      clock, posedge
//   reset       in   1      synchronous, active-high
//   start       in   1      request pulse, only honoured in IDLE
//   pat_data    in   PAT_W  pattern, bit pat_len-1 sent first
//   pat_len     in   LEN_W  pattern length, legal 1..PAT_W
//   repeat_cnt  in   CNT_W  repetitions, 0 = continuous
//   gap_len     in   GAP_W  idle bit-times between repetitions
//   stop        in   1      level, ends the run at the next pattern boundary
//   ser_out     out  1      serial data, 0 when ser_valid is low
//   ser_valid   out  1      ser_out carries a pattern bit
//   frame_start out  1      first bit of each repetition
//   busy        out  1      run in progress, through the done cycle
//   done        out  1      one cycle after the final bit
//   err         out  1      start rejected for an illegal pat_len
// -----------------------------------------------------------------------------
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP_W = DEF_GAP_W,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             stop,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] rep_q, rep_n;
  logic [GAP_W-1:0] gap_len_q, gap_len_n;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_n;
  logic             stop_seen_q, stop_seen_n;

  logic             bit_n;
  logic             fs_n;
  logic             err_n;

  logic             len_ok;
  logic             sh_load;
  logic             sh_shift;
  logic             cur_bit;
  logic             nxt_bit;
  logic             load_bit;
  logic             last_bit;

  assign len_ok = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));

  seq_gen_shifter #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .shift    (sh_shift),
    .data     (pat_data),
    .len      (pat_len),
    .cur_bit  (cur_bit),
    .nxt_bit  (nxt_bit),
    .load_bit (load_bit),
    .last_bit (last_bit)
  );

  // Next-state logic also produces next-cycle output values, so every output
  // comes straight from a flop while the first bit still appears one cycle
  // after start.
  always_comb begin
    state_n     = state_q;
    rep_n       = rep_q;
    gap_len_n   = gap_len_q;
    gap_cnt_n   = gap_cnt_q;
    stop_seen_n = stop_seen_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    bit_n       = 1'b0;
    fs_n        = 1'b0;
    err_n       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_n     = SEND;
            sh_load     = 1'b1;
            rep_n       = repeat_cnt;
            gap_len_n   = gap_len;
            stop_seen_n = 1'b0;
            bit_n       = load_bit;
            fs_n        = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      SEND: begin
        // The index advances every SEND cycle; after bit 0 it wraps to the
        // MSB, which is exactly where both the no-gap repeat and the
        // post-gap repeat need it.
        sh_shift = 1'b1;
        if (!last_bit) begin
          bit_n       = nxt_bit;
          stop_seen_n = stop_seen_q | stop;
        end else begin
          stop_seen_n = 1'b0;
          if (rep_q != '0) rep_n = rep_q - CNT_W'(1);
          if ((rep_q == CNT_W'(1)) || stop_seen_q || stop) begin
            state_n = DONE;
          end else if (gap_len_q != '0) begin
            state_n   = GAP;
            gap_cnt_n = gap_len_q - GAP_W'(1);
          end else begin
            bit_n = nxt_bit;
            fs_n  = 1'b1;
          end
        end
      end

      GAP: begin
        if (stop) begin
          state_n = DONE;
        end else if (gap_cnt_q == '0) begin
          state_n = SEND;
          bit_n   = cur_bit;
          fs_n    = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt_q - GAP_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rep_q       <= '0;
      gap_len_q   <= '0;
      gap_cnt_q   <= '0;
      stop_seen_q <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_n;
      rep_q       <= rep_n;
      gap_len_q   <= gap_len_n;
      gap_cnt_q   <= gap_cnt_n;
      stop_seen_q <= stop_seen_n;
      ser_out     <= bit_n;
      ser_valid   <= (state_n == SEND);
      frame_start <= fs_n;
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
      err         <= err_n;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_gen
//   Directed bench for seq_pattern_gen: a table of start configurations with
//   hand-computed per-cycle output masks, plus hand-written sequences for stop,
//   stop-in-gap, mid-pattern reset and start re-pulsed while busy. A small
//   overlapping "101" Mealy detector model counts detections on the valid bits.
// -----------------------------------------------------------------------------
module tb_seq_pattern_gen;

  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int GAP_W = 3;
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             clk;
  logic             reset;
  logic             start;
  logic [PAT_W-1:0] pat_data;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             stop;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  int det_st  = 0;
  int det_cnt = 0;

  // Masks: bit k-1 holds the expected value in cycle k after the accept edge.
  typedef struct {
    logic [7:0]  data;
    logic [3:0]  len;
    logic [3:0]  rep;
    logic [2:0]  gap;
    int          ncyc;
    logic [15:0] m_out;
    logic [15:0] m_vld;
    logic [15:0] m_fs;
    logic [15:0] m_busy;
    logic [15:0] m_done;
    logic [15:0] m_err;
    int          dets;
  } vec_t;

  vec_t vecs[8];

  seq_pattern_gen #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W),
    .GAP_W (GAP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pat_data    (pat_data),
    .pat_len     (pat_len),
    .repeat_cnt  (repeat_cnt),
    .gap_len     (gap_len),
    .stop        (stop),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] pack_out();
    return {ser_out, ser_valid, frame_start, busy, done, err};
  endfunction

  task automatic chk(input string name, input int tag,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, tag, act, exp);
    end
  endtask

  // Overlapping "101" Mealy detector, advanced once per valid bit.
  task automatic det_step();
    if (ser_valid) begin
      case (det_st)
        0: det_st = ser_out ? 1 : 0;
        1: det_st = ser_out ? 1 : 2;
        default: begin
          if (ser_out) begin
            det_cnt++;
            det_st = 1;
          end else begin
            det_st = 0;
          end
        end
      endcase
    end
  endtask

  task automatic launch(input logic [7:0] d, input logic [3:0] l,
                        input logic [3:0] r, input logic [2:0] g);
    @(negedge clk);
    det_st     = 0;
    det_cnt    = 0;
    pat_data   = d;
    pat_len    = l;
    repeat_cnt = r;
    gap_len    = g;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id, input bit disturb);
    logic [5:0] exp;
    launch(v.data, v.len, v.rep, v.gap);
    for (int k = 1; k <= v.ncyc; k++) begin
      if (k > 1) @(negedge clk);
      exp = {v.m_out[k-1], v.m_vld[k-1], v.m_fs[k-1],
             v.m_busy[k-1], v.m_done[k-1], v.m_err[k-1]};
      chk($sformatf("vec%0d_cycle", id), k, {26'd0, pack_out()}, {26'd0, exp});
      det_step();
      if (disturb && k == 2) begin
        start      = 1'b1;
        pat_data   = 8'hFF;
        pat_len    = 4'd8;
        repeat_cnt = 4'd5;
        gap_len    = 3'd1;
      end
      if (disturb && k == 3) start = 1'b0;
    end
    chk($sformatf("vec%0d_det101", id), 0, det_cnt, v.dets);
  endtask

  initial begin
    int nbits;
    int bad;
    int done_at;

    // 101 twice back-to-back
    vecs[0] = '{data:8'h05, len:4'd3, rep:4'd2, gap:3'd0, ncyc:8,
                m_out:16'h002D, m_vld:16'h003F, m_fs:16'h0009,
                m_busy:16'h007F, m_done:16'h0040, m_err:16'h0000, dets:2};
    // 101 twice with a 2-bit gap
    vecs[1] = '{data:8'h05, len:4'd3, rep:4'd2, gap:3'd2, ncyc:10,
                m_out:16'h00A5, m_vld:16'h00E7, m_fs:16'h0021,
                m_busy:16'h01FF, m_done:16'h0100, m_err:16'h0000, dets:2};
    // illegal length 0
    vecs[2] = '{data:8'h05, len:4'd0, rep:4'd2, gap:3'd0, ncyc:3,
                m_out:16'h0, m_vld:16'h0, m_fs:16'h0,
                m_busy:16'h0, m_done:16'h0, m_err:16'h0001, dets:0};
    // illegal length 9
    vecs[3] = '{data:8'hFF, len:4'd9, rep:4'd1, gap:3'd0, ncyc:3,
                m_out:16'h0, m_vld:16'h0, m_fs:16'h0,
                m_busy:16'h0, m_done:16'h0, m_err:16'h0001, dets:0};
    // single-bit pattern, 3 back-to-back repeats
    vecs[4] = '{data:8'h01, len:4'd1, rep:4'd3, gap:3'd0, ncyc:5,
                m_out:16'h0007, m_vld:16'h0007, m_fs:16'h0007,
                m_busy:16'h000F, m_done:16'h0008, m_err:16'h0000, dets:0};
    // full-width pattern 1011_0100, once
    vecs[5] = '{data:8'hB4, len:4'd8, rep:4'd1, gap:3'd0, ncyc:10,
                m_out:16'h002D, m_vld:16'h00FF, m_fs:16'h0001,
                m_busy:16'h01FF, m_done:16'h0100, m_err:16'h0000, dets:2};
    // upper bits ignored: 4-bit 1001 from 8'hF9, gap unused on a single run
    vecs[6] = '{data:8'hF9, len:4'd4, rep:4'd1, gap:3'd3, ncyc:6,
                m_out:16'h0009, m_vld:16'h000F, m_fs:16'h0001,
                m_busy:16'h001F, m_done:16'h0010, m_err:16'h0000, dets:0};
    // single bit with a 1-bit gap
    vecs[7] = '{data:8'h01, len:4'd1, rep:4'd2, gap:3'd1, ncyc:5,
                m_out:16'h0005, m_vld:16'h0005, m_fs:16'h0005,
                m_busy:16'h000F, m_done:16'h0008, m_err:16'h0000, dets:0};

    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    pat_data   = '0;
    pat_len    = '0;
    repeat_cnt = '0;
    gap_len    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 0, {26'd0, pack_out()}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_state", 0, {26'd0, pack_out()}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i, 1'b0);

    // Continuous run, stop raised in the middle of the 3rd repetition.
    nbits   = 0;
    bad     = 0;
    done_at = 0;
    launch(8'h05, 4'd3, 4'd0, 3'd0);
    for (int k = 1; k <= 30 && done_at == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (ser_valid) begin
        if (ser_out !== ((nbits % 3) != 1)) bad++;
        nbits++;
      end
      det_step();
      if (done) done_at = k;
      if (k == 8) stop = 1'b1;
    end
    stop = 1'b0;
    chk("stop_bits", 0, nbits, 9);
    chk("stop_done_cycle", 0, done_at, 10);
    chk("stop_bit_values", 0, bad, 0);
    chk("stop_det101", 0, det_cnt, 3);
    @(negedge clk);
    chk("stop_idle_after", 0, {26'd0, pack_out()}, 32'd0);

    // Stop raised during the gap: no further repetition, done next cycle.
    launch(8'h05, 4'd3, 4'd0, 3'd2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("gapstop_gap", 0, {26'd0, pack_out()}, 32'b000100);
    stop = 1'b1;
    @(negedge clk);
    chk("gapstop_done", 0, {26'd0, pack_out()}, 32'b000110);
    stop = 1'b0;
    @(negedge clk);
    chk("gapstop_idle", 0, {26'd0, pack_out()}, 32'd0);

    // Reset in cycle 2 of a SEND: outputs clear next cycle, no done.
    launch(8'h05, 4'd3, 4'd2, 3'd0);
    chk("rst_cycle1", 0, {26'd0, pack_out()}, 32'b111100);
    @(negedge clk);
    chk("rst_cycle2", 0, {26'd0, pack_out()}, 32'b010100);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cleared", 0, {26'd0, pack_out()}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_no_done", 0, {26'd0, pack_out()}, 32'd0);
    run_vec(vecs[0], 100, 1'b0);

    // start re-pulsed while busy with different inputs: stream unchanged.
    run_vec(vecs[1], 200, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
